// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: mode encodings, round counts and the
// sequencer state type.
package aes_pkg;

  localparam logic [1:0] AES128 = 2'd0;
  localparam logic [1:0] AES192 = 2'd2;
  localparam logic [1:0] AES256 = 2'd3;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SET,
    ST_RUN,
    ST_FLUSH,
    ST_READY
  } ks_state_e;

  // Number of cipher rounds for a mode; mode 1 is treated as AES-128.
  function automatic logic [3:0] nr_of_mode(input logic [1:0] mode);
    logic [3:0] nr;
    case (mode)
      AES192:       nr = NR_192;
      AES256:       nr = NR_256;
      AES128, 2'd1: nr = NR_128;
      default:      nr = NR_128;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: one synchronous write port, one registered read
// port. Reads beyond the last entry or beyond the active round count give 0.
module aes_rk_store #(
  parameter int RK_W   = 128,
  parameter int RK_NUM = 15,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [RK_W-1:0]  wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [IDX_W-1:0] rd_lim,
  output logic [RK_W-1:0]  rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RK_NUM - 1);

  logic [RK_W-1:0] mem_q [RK_NUM];
  logic [RK_W-1:0] rd_data_q;
  logic [RK_W-1:0] rd_data_d;
  logic            rd_in_range;

  // Entry write; the whole array clears on reset so no stale schedule survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RK_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && (wr_idx <= LAST_IDX)) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Read mux with range gating against both store depth and round count.
  always_comb begin
    rd_in_range = (rd_idx <= LAST_IDX) && (rd_idx <= rd_lim);
    rd_data_d   = '0;
    if (rd_in_range) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  // Registered read data, one cycle after the index is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule sequencer: drives keyExpansion through rounds 0..Nr,
// captures each registered round key into the store, and serves random
// access reads for the cipher core.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_W  = 256,
  parameter int RK_W   = 128,
  parameter int RK_NUM = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode_in,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             keys_ready,
  output logic [3:0]       num_rounds,
  output logic [4:0]       exp_round,
  output logic [KEY_W-1:0] exp_key,
  output logic             exp_init,
  output logic             exp_set,
  output logic [1:0]       exp_mode,
  input  logic [RK_W-1:0]  exp_roundkey,
  input  logic [3:0]       rd_idx,
  output logic [RK_W-1:0]  rd_key
);

  ks_state_e        state_q, state_d;
  logic [4:0]       round_q, round_d;
  logic [3:0]       nr_q, nr_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [1:0]       mode_q, mode_d;
  logic             drive;
  logic             vld_p1_q;
  logic [3:0]       idx_p1_q;

  // Control and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      nr_q     <= '0;
      key_q    <= '0;
      mode_q   <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      nr_q     <= nr_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      vld_p1_q <= drive;
    end
  end

  // --- capture stage p1: keyExpansion output lags the driven round by one cycle
  // Index travels with the write strobe; it only matters while vld_p1_q is set.
  always_ff @(posedge clk) begin
    idx_p1_q <= round_q[3:0];
  end

  // Sequencer next-state: accept in IDLE/READY, then walk rounds 0..Nr.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    key_d   = key_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (start) begin
          state_d = ST_INIT;
          round_d = '0;
          nr_d    = nr_of_mode(mode_in);
          key_d   = key_in;
          mode_d  = mode_in;
        end
      end
      ST_INIT: begin
        round_d = 5'd1;
        // Wider keys need an extra load step before the iterative rounds.
        if ((mode_q == AES192) || (mode_q == AES256)) begin
          state_d = ST_SET;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SET: begin
        round_d = 5'd2;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (round_q == {1'b0, nr_q}) begin
          state_d = ST_FLUSH;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy       = 1'b0;
    keys_ready = 1'b0;
    exp_init   = 1'b0;
    exp_set    = 1'b0;
    drive      = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy     = 1'b1;
        exp_init = 1'b1;
        drive    = 1'b1;
      end
      ST_SET: begin
        busy    = 1'b1;
        exp_set = 1'b1;
        drive   = 1'b1;
      end
      ST_RUN: begin
        busy  = 1'b1;
        drive = 1'b1;
      end
      ST_FLUSH: begin
        busy = 1'b1;
      end
      ST_READY: begin
        keys_ready = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign exp_round  = round_q;
  assign exp_key    = key_q;
  assign exp_mode   = mode_q;
  assign num_rounds = nr_q;

  aes_rk_store #(
    .RK_W   (RK_W),
    .RK_NUM (RK_NUM),
    .IDX_W  (4)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vld_p1_q),
    .wr_idx  (idx_p1_q),
    .wr_data (exp_roundkey),
    .rd_idx  (rd_idx),
    .rd_lim  (nr_q),
    .rd_data (rd_key)
  );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural keyExpansion
// stand-in that returns FIPS-197 round keys one cycle after the request.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2B  = 256'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode_in = 2'd0;
  logic [255:0] key_in = '0;
  logic         busy, keys_ready, exp_init, exp_set;
  logic [3:0]   num_rounds;
  logic [4:0]   exp_round;
  logic [255:0] exp_key;
  logic [1:0]   exp_mode;
  logic [127:0] exp_roundkey = '0;
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode_in      (mode_in),
    .key_in       (key_in),
    .busy         (busy),
    .keys_ready   (keys_ready),
    .num_rounds   (num_rounds),
    .exp_round    (exp_round),
    .exp_key      (exp_key),
    .exp_init     (exp_init),
    .exp_set      (exp_set),
    .exp_mode     (exp_mode),
    .exp_roundkey (exp_roundkey),
    .rd_idx       (rd_idx),
    .rd_key       (rd_key)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base, s;
    logic [7:0] e;
    inv = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    if (x == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Full FIPS-197 expansion, returning round key rnd.
  function automatic logic [127:0] rk_of(input logic [255:0] key, input logic [1:0] mode,
                                         input logic [4:0] rnd);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, r;
    nk = (mode == 2'd2) ? 6 : ((mode == 2'd3) ? 8 : 4);
    for (int i = 0; i < nk; i++) w[i] = key[(nk * 32 - 1) - 32 * i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 60; i++) begin
      t = w[i-1];
      if ((i % nk) == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if ((nk == 8) && ((i % nk) == 4)) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    r = int'(rnd);
    if (r > 14) r = 14;
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // keyExpansion stand-in: registered round key for the driven round.
  always @(posedge clk) exp_roundkey <= rk_of(exp_key, exp_mode, exp_round);

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    rd_idx = idx;
    @(negedge clk);
    check(tag, 256'(rd_key), 256'(exp));
  endtask

  // Issue start at a negedge, follow the run cycle by cycle and check protocol.
  task automatic run_expand(input string tag, input logic [255:0] key, input logic [1:0] mode,
                            input int nr, input bit pulse_mid);
    int n, inits, sets, init_at, set_at, ready_at, bad_round;
    inits = 0; sets = 0; init_at = -1; set_at = -1; ready_at = -1; bad_round = 0;
    key_in = key; mode_in = mode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, "_busy_rise"}, 256'(busy), 256'(1'b1));
    check({tag, "_ready_drop"}, 256'(keys_ready), 256'(1'b0));
    while ((ready_at < 0) && (n <= 40)) begin
      if (exp_init) begin inits++; init_at = n; end
      if (exp_set) begin sets++; set_at = n; end
      if ((n <= nr + 1) && (exp_round !== 5'(n - 1))) bad_round++;
      if (keys_ready) ready_at = n;
      if (pulse_mid && (n == 5)) begin
        start = 1'b1; key_in = ~key; mode_in = 2'd0;
      end else begin
        start = 1'b0;
      end
      if (ready_at < 0) begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_ready_cycle"}, 256'(ready_at), 256'(nr + 3));
    check({tag, "_num_rounds"}, 256'(num_rounds), 256'(nr));
    check({tag, "_busy_done"}, 256'(busy), 256'(1'b0));
    check({tag, "_init_count"}, 256'(inits), 256'(1));
    check({tag, "_init_cycle"}, 256'(init_at), 256'(1));
    check({tag, "_set_count"}, 256'(sets), 256'((mode >= 2'd2) ? 1 : 0));
    check({tag, "_set_cycle"}, 256'(set_at), 256'((mode >= 2'd2) ? 2 : -1));
    check({tag, "_round_seq_errs"}, 256'(bad_round), 256'(0));
    check({tag, "_exp_key"}, exp_key, key);
    check({tag, "_exp_mode"}, 256'(exp_mode), 256'(mode));
  endtask

  initial begin
    #2;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_ready", 256'(keys_ready), 256'(0));
    check("rst_init", 256'(exp_init), 256'(0));
    check("rst_set", 256'(exp_set), 256'(0));
    check("rst_nr", 256'(num_rounds), 256'(0));
    check("rst_round", 256'(exp_round), 256'(0));
    check("rst_key", exp_key, 256'(0));
    check("rst_mode", 256'(exp_mode), 256'(0));
    check("rst_rdkey", 256'(rd_key), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128 FIPS-197 key
    run_expand("a128", K128, 2'd0, 10, 1'b0);
    rd_check("a128_rk0", 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    rd_check("a128_rk10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rd_check("a128_rk11_oob", 4'd11, 128'h0);

    // AES-192 with a start pulse mid-expansion that must be ignored
    run_expand("a192", K192, 2'd2, 12, 1'b1);
    rd_check("a192_rk0", 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    rd_check("a192_rk12", 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d);
    rd_check("a192_rk13_oob", 4'd13, 128'h0);

    // AES-256
    run_expand("a256", K256, 2'd3, 14, 1'b0);
    rd_check("a256_rk1", 4'd1, 128'h101112131415161718191a1b1c1d1e1f);
    rd_check("a256_rk14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rd_check("a256_rk15_oob", 4'd15, 128'h0);

    // Restart from READY with a new AES-128 key, encoded as mode 1
    run_expand("re128", K2B, 2'd1, 10, 1'b0);
    rd_check("re128_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_check("re128_rk0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd_check("re128_rk14_hidden", 4'd14, 128'h0);

    // Asynchronous reset during RUN
    rd_idx = 4'd10;
    key_in = K256; mode_in = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before", 256'(busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_ready", 256'(keys_ready), 256'(0));
    check("mid_rst_round", 256'(exp_round), 256'(0));
    check("mid_rst_key", exp_key, 256'(0));
    check("mid_rst_nr", 256'(num_rounds), 256'(0));
    check("mid_rst_rdkey", 256'(rd_key), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("mid_rst_store0", 4'd0, 128'h0);
    run_expand("post", K256, 2'd3, 14, 1'b0);
    rd_check("post_rk14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rd_check("post_rk1", 4'd1, 128'h101112131415161718191a1b1c1d1e1f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
